// File: rtl/try_pkg.sv
// Shared widths, FSM state type and factorial reference table for the try block.
package try_pkg;

    localparam int unsigned IN_W  = 3;
    localparam int unsigned OUT_W = 13;
    localparam int unsigned K_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    // Reference values for benches only; the datapath computes iteratively.
    localparam logic [OUT_W-1:0] FACT_LUT [8] = '{
        13'd1, 13'd1, 13'd2, 13'd6, 13'd24, 13'd120, 13'd720, 13'd5040
    };

endpackage

// File: rtl/try_mul.sv
// Combinational 13x4 -> 13 unsigned multiplier built from shift-and-add partial products.
module try_mul
    import try_pkg::*;
(
    input  logic [OUT_W-1:0] a_i,
    input  logic [K_W-1:0]   b_i,
    output logic [OUT_W-1:0] prod_c_o
);

    always_comb begin
        prod_c_o = '0;
        for (int unsigned i = 0; i < K_W; i++) begin
            if (b_i[i]) begin
                prod_c_o = prod_c_o + (a_i << i);
            end
        end
    end

endmodule

// File: rtl/try.sv
// Iterative factorial of a 3-bit operand: one multiply per cycle, result held until the next completion.
module try
    import try_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    state_e           state_q, state_d;
    logic [IN_W-1:0]  n_q, n_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic [OUT_W-1:0] prod_c;
    logic             new_sample_c;

    try_mul u_mul (
        .a_i      (acc_q),
        .b_i      (k_q),
        .prod_c_o (prod_c)
    );

    assign new_sample_c = first_q || (in != n_q);

    // Next-state: a new sample restarts from any state; otherwise step or finish in CALC.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = valid_q;
        first_d = first_q;

        if (new_sample_c) begin
            n_d     = in;
            acc_d   = OUT_W'(1);
            k_d     = K_W'(2);
            valid_d = 1'b0;
            first_d = 1'b0;
            state_d = CALC;
        end else begin
            case (state_q)
                CALC: begin
                    if (k_q <= K_W'(n_q)) begin
                        acc_d = prod_c;
                        k_d   = k_q + K_W'(1);
                    end else begin
                        out_d   = acc_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= K_W'(2);
            acc_q   <= OUT_W'(1);
            out_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            first_q <= first_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_try.sv
// Directed and random checks of try against a cycle-count reference model of the factorial block.
module tb_try;
    import try_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  in_r;
    logic [OUT_W-1:0] out_w;
    logic             valid_w;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: sampled operand, edges left until completion, visible result.
    int unsigned m_n     = 0;
    int unsigned m_rem   = 0;
    logic        m_busy  = 1'b0;
    logic        m_first = 1'b1;
    int unsigned m_out   = 0;
    logic        m_valid = 1'b0;
    logic        seen_5040 = 1'b0;

    always #5 clk = ~clk;

    try dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in_r),
        .out   (out_w),
        .valid (valid_w)
    );

    function automatic int unsigned fact(input int unsigned n);
        int unsigned r = 1;
        for (int unsigned i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge: advance the model, then compare DUT outputs away from the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_n = 0; m_busy = 1'b0; m_first = 1'b1; m_out = 0; m_valid = 1'b0;
        end else if (m_first || (int'(in_r) != int'(m_n))) begin
            m_n     = int'(in_r);
            m_first = 1'b0;
            m_valid = 1'b0;
            m_busy  = 1'b1;
            m_rem   = (m_n > 1) ? m_n : 1;
        end else if (m_busy) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_busy  = 1'b0;
                m_out   = fact(m_n);
                m_valid = 1'b1;
            end
        end
        #1;
        if (out_w == 13'd5040) seen_5040 = 1'b1;
        check("model_out", 32'(out_w), 32'(m_out));
        check("model_valid", 32'(valid_w), 32'(m_valid));
        if (valid_w === 1'b1) check("valid_out_fact", 32'(out_w), 32'(fact(m_n)));
    endtask

    initial begin
        int lat;
        int unsigned hold;

        // Reset with in=0, then first released edge samples.
        rst  = 1'b1;
        in_r = 3'd0;
        tick();
        tick();
        check("reset_out", 32'(out_w), 32'd0);
        check("reset_valid", 32'(valid_w), 32'd0);
        rst = 1'b0;
        tick();
        check("release_sample_valid", 32'(valid_w), 32'd0);
        tick();
        check("release_out", 32'(out_w), 32'd1);
        check("release_valid", 32'(valid_w), 32'd1);

        // Sweep 0..7, 10 cycles each, measuring latency from the sampling edge.
        for (int n = 0; n < 8; n++) begin
            in_r = 3'(n);
            lat  = -1;
            for (int c = 1; c <= 10; c++) begin
                tick();
                if (lat < 0 && valid_w === 1'b1) lat = c - 1;
            end
            check("sweep_out", 32'(out_w), 32'(fact(n)));
            check("sweep_lut", 32'(out_w), 32'(FACT_LUT[n]));
            check("sweep_valid", 32'(valid_w), 32'd1);
            if (n > 0) check("sweep_latency", 32'(lat), 32'((n > 1) ? n : 1));
        end

        // Abort: 7 started, switched to 3 mid-computation.
        in_r = 3'd0;
        repeat (3) tick();
        check("abort_pre_out", 32'(out_w), 32'd1);
        seen_5040 = 1'b0;
        in_r = 3'd7;
        repeat (3) tick();
        in_r = 3'd3;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("abort_valid_low", 32'(valid_w), 32'd0);
            check("abort_out_hold", 32'(out_w), 32'd1);
        end
        tick();
        check("abort_out6", 32'(out_w), 32'd6);
        check("abort_valid", 32'(valid_w), 32'd1);
        check("abort_no_5040", 32'(seen_5040), 32'd0);

        // Steady operand: no restart.
        in_r = 3'd5;
        repeat (6) tick();
        check("hold_first_out", 32'(out_w), 32'd120);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("hold_out", 32'(out_w), 32'd120);
            check("hold_valid", 32'(valid_w), 32'd1);
        end

        // Reset mid-computation of 6!.
        in_r = 3'd6;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrst_out", 32'(out_w), 32'd0);
        check("midrst_valid", 32'(valid_w), 32'd0);
        rst = 1'b0;
        tick();
        repeat (5) tick();
        check("midrst_not_yet", 32'(valid_w), 32'd0);
        tick();
        check("midrst_out720", 32'(out_w), 32'd720);
        check("midrst_valid_hi", 32'(valid_w), 32'd1);

        // Random operand changes every 1..10 cycles.
        for (int i = 0; i < 300; i++) begin
            in_r = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 10);
            repeat (hold) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
